motor_cmd_driver: RTL and testbench

MOTOR_CMD_DRIVER -- requirements
Module: motor_cmd_driver

---
 rtl/motor_cmd_driver.sv | 115 +++++++++++
 tb/tb_motor_cmd_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_driver.sv
// motor_cmd_driver: dual H-bridge driver with dead-time reversal, wrap-aligned PWM duty and command watchdog
module motor_cmd_driver #(
    parameter int PRESCALE    = 10,
    parameter int DEAD_CYCLES = 5000,
    parameter int WDOG_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [8:0] cmd_speed1,
    input  logic [8:0] cmd_speed2,
    output logic       ina1,
    output logic       inb1,
    output logic       ina2,
    output logic       inb2,
    output logic       pwm1,
    output logic       pwm2,
    output logic       timeout
);
    localparam logic [1:0] IDLE = 2'd0, FWD = 2'd1, REV = 2'd2, DEAD = 2'd3;
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic          alive, acc, expire, tick, wrap;
    logic [15:0]   pre;
    logic [7:0]    cnt;
    logic [WW-1:0] wd;
    logic [1:0]    dead, ina, inb, pwm;
    logic [8:0]    speed [2];

    assign speed[0]  = cmd_speed1;
    assign speed[1]  = cmd_speed2;
    assign cmd_ready = alive && dead == 2'b00;
    assign acc       = cmd_valid && cmd_ready;
    assign tick      = pre == 16'(PRESCALE - 1);
    assign wrap      = tick && cnt == 8'hff;
    assign expire    = wd == WW'(WDOG_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive   <= 1'b0;
            pre     <= '0;
            cnt     <= '0;
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            alive <= 1'b1;
            pre   <= tick ? '0 : pre + 16'd1;
            if (tick) cnt <= cnt + 8'd1;
            if (acc) wd <= '0;
            else if (wd != WW'(WDOG_CYCLES)) wd <= wd + 1'b1;
            if (acc) timeout <= 1'b0;
            else if (expire) timeout <= 1'b1;
        end
    end

    for (genvar m = 0; m < 2; m++) begin : g_motor
        logic [1:0]    state;
        logic          pend_rev;
        logic [DW-1:0] dcnt;
        logic [7:0]    duty, next_duty, mag;
        logic [8:0]    neg;
        always_comb begin
            neg = -speed[m];
            mag = !speed[m][8] ? speed[m][7:0] : (neg[8] ? 8'hff : neg[7:0]);
        end
        // Same-sign commands only stage the duty; it goes live at the counter wrap.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state     <= IDLE;
                pend_rev  <= 1'b0;
                dcnt      <= '0;
                duty      <= '0;
                next_duty <= '0;
            end else if (acc) begin
                next_duty <= mag;
                if (wrap) duty <= mag;
                if (speed[m] == 9'd0) state <= IDLE;
                else if (state == IDLE) begin
                    state <= speed[m][8] ? REV : FWD;
                    duty  <= mag;
                end else if ((state == FWD) == speed[m][8]) begin
                    state    <= DEAD;
                    pend_rev <= speed[m][8];
                    dcnt     <= '0;
                end
            end else if (expire) begin
                state     <= IDLE;
                duty      <= '0;
                next_duty <= '0;
            end else begin
                if (wrap) duty <= next_duty;
                if (state == DEAD) begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DW'(DEAD_CYCLES - 1)) begin
                        state <= pend_rev ? REV : FWD;
                        duty  <= next_duty;
                    end
                end
            end
        end
        assign dead[m] = state == DEAD;
        assign ina[m]  = state == FWD;
        assign inb[m]  = state == REV;
        assign pwm[m]  = (state == FWD || state == REV) && cnt < duty;
    end

    assign ina1 = ina[0];
    assign inb1 = inb[0];
    assign pwm1 = pwm[0];
    assign ina2 = ina[1];
    assign inb2 = inb[1];
    assign pwm2 = pwm[1];
endmodule

// File: tb/tb_motor_cmd_driver.sv
// tb_motor_cmd_driver: directed checks of PWM duty, dead-time reversal, reset and watchdog
module tb_motor_cmd_driver;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [8:0] cmd_speed1 = '0, cmd_speed2 = '0;
    logic ina1, inb1, ina2, inb2, pwm1, pwm2, timeout;
    logic w_valid = 1'b0, w_ready;
    logic [8:0] w_s1 = '0, w_s2 = '0;
    logic w_ina1, w_inb1, w_ina2, w_inb2, w_pwm1, w_pwm2, w_timeout;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    motor_cmd_driver #(.PRESCALE(2), .DEAD_CYCLES(8), .WDOG_CYCLES(100000)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed1(cmd_speed1), .cmd_speed2(cmd_speed2),
        .ina1(ina1), .inb1(inb1), .ina2(ina2), .inb2(inb2),
        .pwm1(pwm1), .pwm2(pwm2), .timeout(timeout)
    );

    motor_cmd_driver #(.PRESCALE(1), .DEAD_CYCLES(4), .WDOG_CYCLES(20)) dut_w (
        .clk(clk), .rst_n(rst_n), .cmd_valid(w_valid), .cmd_ready(w_ready),
        .cmd_speed1(w_s1), .cmd_speed2(w_s2),
        .ina1(w_ina1), .inb1(w_inb1), .ina2(w_ina2), .inb2(w_inb2),
        .pwm1(w_pwm1), .pwm2(w_pwm2), .timeout(w_timeout)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [8:0] s1, input logic [8:0] s2);
        cmd_speed1 = s1;
        cmd_speed2 = s2;
        cmd_valid  = 1'b1;
        step(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic wsend(input logic [8:0] s1);
        w_s1    = s1;
        w_valid = 1'b1;
        step(1);
        w_valid = 1'b0;
    endtask

    task automatic count_high(output int h1, output int h2);
        h1 = 0;
        h2 = 0;
        for (int i = 0; i < 512; i++) begin
            h1 += int'(pwm1);
            h2 += int'(pwm2);
            step(1);
        end
    endtask

    task automatic wait_pwm1(input logic lvl, input string tag);
        int k = 0;
        while (pwm1 !== lvl && k < 600) begin
            step(1);
            k++;
        end
        chk(tag, 32'(pwm1), 32'(lvl));
    endtask

    initial begin
        int h1, h2, bad;
        step(2);
        chk("reset_outputs", 32'({cmd_ready, ina1, inb1, pwm1, ina2, inb2, pwm2, timeout}), 32'd0);
        chk("reset_outputs_w", 32'({w_ready, w_ina1, w_inb1, w_pwm1, w_timeout}), 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        send(9'd128, 9'd0);
        chk("fwd_dir", 32'({ina1, inb1}), 32'b10);
        count_high(h1, h2);
        chk("duty_128", 32'(h1), 32'd256);

        send(9'h1C0, 9'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if ({ina1, inb1, pwm1, cmd_ready} !== 4'b0000) bad++;
            step(1);
        end
        chk("dead_window", 32'(bad), 32'd0);
        chk("rev_dir_after_dead", 32'({ina1, inb1, cmd_ready}), 32'b011);
        count_high(h1, h2);
        chk("duty_64", 32'(h1), 32'd128);

        send(9'd0, 9'd0);
        chk("idle_after_zero", 32'({ina1, inb1, pwm1}), 32'd0);
        send(9'd200, 9'd0);
        chk("fwd_from_idle", 32'({ina1, inb1}), 32'b10);
        wait_pwm1(1'b0, "wait_low");
        wait_pwm1(1'b1, "wait_period_start");
        h1 = 0;
        for (int i = 0; i < 512; i++) begin
            h1 += int'(pwm1);
            if (i == 100) begin
                cmd_speed1 = 9'd50;
                cmd_valid  = 1'b1;
            end
            if (i == 101) cmd_valid = 1'b0;
            step(1);
        end
        chk("period_kept_200", 32'(h1), 32'd400);
        count_high(h1, h2);
        chk("next_period_50", 32'(h1), 32'd100);

        send(9'd50, 9'h100);
        chk("m2_rev", 32'({ina1, inb1, ina2, inb2}), 32'b1001);
        count_high(h1, h2);
        chk("m2_duty_255", 32'(h2), 32'd510);
        chk("m1_duty_50", 32'(h1), 32'd100);
        send(9'd50, 9'd0);
        chk("m2_idle", 32'({ina2, inb2, pwm2}), 32'd0);

        send(9'h1F6, 9'd0);
        step(3);
        chk("in_dead", 32'({ina1, inb1, cmd_ready}), 32'd0);
        rst_n = 1'b0;
        step(1);
        chk("reset_mid_dead", 32'({cmd_ready, ina1, inb1, pwm1, ina2, inb2, pwm2, timeout}), 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("ready_after_dead_reset", 32'({cmd_ready, ina1, inb1}), 32'b100);
        step(12);
        chk("no_dead_completion", 32'({ina1, inb1, pwm1}), 32'd0);

        step(20);
        chk("w_timeout_idle", 32'(w_timeout), 32'd1);
        wsend(9'd100);
        chk("w_accept_clears", 32'({w_timeout, w_ina1, w_inb1}), 32'b010);
        step(19);
        chk("w_before_expiry", 32'({w_timeout, w_ina1}), 32'b01);
        step(1);
        chk("w_expiry", 32'({w_timeout, w_ina1, w_inb1, w_pwm1, w_ina2, w_inb2, w_pwm2}), 32'b1000000);
        wsend(9'd30);
        chk("w_recover", 32'({w_timeout, w_ina1}), 32'b01);
        step(19);
        wsend(9'd30);
        chk("w_accept_on_expiry", 32'({w_timeout, w_ina1}), 32'b01);
        step(19);
        chk("w_restart_hold", 32'(w_timeout), 32'd0);
        step(1);
        chk("w_restart_expiry", 32'({w_timeout, w_ina1}), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
